program_loader: RTL and testbench



---
 rtl/program_loader.sv | 194 +++++++++++++++++++
 tb/tb_program_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Boot-time loader placed in front of the core's instruction
//            memory. It takes a byte stream over a valid/ready handshake and
//            assembles little-endian 32-bit words. The words are written to
//            instruction memory from address 0. Core_Run is held low until
//            the whole image is in place. Start re-arms the loader from DONE
//            or ERROR.
// Stream   : LEN_LO, LEN_HI (word count N), then 4*N data bytes (LSB first).
//            With LOADER_CHECKSUM_EN defined, one more byte follows: the XOR
//            of all length and data bytes.
// Ports    : Clk, Rst_n (async, active-low), Start (re-arm pulse),
//            In_Valid/In_Data/In_Ready (byte stream),
//            ImWr/ImAddr/ImData (instruction-memory write port),
//            Core_Run (image loaded), Load_Error (image rejected, sticky),
//            Word_Count (words written in the current load).
// Macros   : LOADER_CHECKSUM_EN - enables the trailing checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             In_Valid,
  input  logic [7:0]       In_Data,
  output logic             In_Ready,
  output logic             ImWr,
  output logic [31:0]      ImAddr,
  output logic [31:0]      ImData,
  output logic             Core_Run,
  output logic             Load_Error,
  output logic [CNT_W-1:0] Word_Count
);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  state_t      rState;
  logic [7:0]  rLenLo;
  logic [15:0] rRemain;    // words still to be received
  logic [1:0]  rByteCnt;   // byte position within the current word
  logic [23:0] rWord;      // first three bytes of the word being assembled
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  rChk;       // running XOR of length and data bytes
`endif

  logic        wAccept;
  logic [15:0] wLen;

  assign wAccept = In_Valid && In_Ready;
  assign wLen    = {In_Data, rLenLo};

  // In_Ready is registered alongside the state transition so that it always
  // reflects the state being entered. Core_Run is set one edge after DONE is
  // entered. This keeps it clear of the final ImWr cycle by a full cycle.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rState     <= S_LEN_LO;
      rLenLo     <= 8'd0;
      rRemain    <= 16'd0;
      rByteCnt   <= 2'd0;
      rWord      <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
      rChk       <= 8'd0;
`endif
      In_Ready   <= 1'b1;
      ImWr       <= 1'b0;
      ImAddr     <= 32'd0;
      ImData     <= 32'd0;
      Core_Run   <= 1'b0;
      Load_Error <= 1'b0;
      Word_Count <= '0;
    end else begin
      ImWr <= 1'b0;
      case (rState)
        S_LEN_LO: begin
          if (wAccept) begin
            rLenLo <= In_Data;
`ifdef LOADER_CHECKSUM_EN
            rChk   <= In_Data;
`endif
            rState <= S_LEN_HI;
          end
        end

        S_LEN_HI: begin
          if (wAccept) begin
            rRemain  <= wLen;
            rByteCnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            rChk     <= rChk ^ In_Data;
`endif
            if (int'(wLen) > DEPTH_WORDS) begin
              rState     <= S_ERROR;
              In_Ready   <= 1'b0;
              Load_Error <= 1'b1;
            end else if (wLen == 16'd0) begin
              rState   <= S_FLUSH;
              In_Ready <= 1'b0;
            end else begin
              rState <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (wAccept) begin
            rByteCnt <= rByteCnt + 2'd1;
            rWord    <= {In_Data, rWord[23:8]};
`ifdef LOADER_CHECKSUM_EN
            rChk     <= rChk ^ In_Data;
`endif
            if (rByteCnt == 2'd3) begin
              ImWr       <= 1'b1;
              ImData     <= {In_Data, rWord};
              ImAddr     <= 32'(Word_Count) << 2;
              Word_Count <= Word_Count + C_CNT_ONE;
              rRemain    <= rRemain - 16'd1;
              if (rRemain == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                rState   <= S_CHK;
`else
                rState   <= S_FLUSH;
                In_Ready <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (wAccept) begin
            In_Ready <= 1'b0;
            if (In_Data == rChk) begin
              rState <= S_FLUSH;
            end else begin
              rState     <= S_ERROR;
              Load_Error <= 1'b1;
            end
          end
        end
`endif

        // Lets the last ImWr land before the core is released.
        S_FLUSH: begin
          rState <= S_DONE;
        end

        S_DONE: begin
          if (Start) begin
            rState     <= S_LEN_LO;
            In_Ready   <= 1'b1;
            Core_Run   <= 1'b0;
            Load_Error <= 1'b0;
            Word_Count <= '0;
          end else begin
            Core_Run <= 1'b1;
          end
        end

        S_ERROR: begin
          if (Start) begin
            rState     <= S_LEN_LO;
            In_Ready   <= 1'b1;
            Core_Run   <= 1'b0;
            Load_Error <= 1'b0;
            Word_Count <= '0;
          end
        end

        default: begin
          rState   <= S_LEN_LO;
          In_Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Self-checking bench for program_loader. An image-level model
//            turns each byte image into the expected list of memory writes
//            and the expected final status. A monitor compares every ImWr
//            against that list. Directed tests cover reset, full-rate and
//            gapped loads, zero length, oversize length, re-arm, and (with
//            LOADER_CHECKSUM_EN) checksum rejection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int DEPTH = 1024;
  localparam int CW    = 16;

  logic          Clk;
  logic          Rst_n;
  logic          Start;
  logic          In_Valid;
  logic [7:0]    In_Data;
  logic          In_Ready;
  logic          ImWr;
  logic [31:0]   ImAddr;
  logic [31:0]   ImData;
  logic          Core_Run;
  logic          Load_Error;
  logic [CW-1:0] Word_Count;

  program_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .In_Valid   (In_Valid),
    .In_Data    (In_Data),
    .In_Ready   (In_Ready),
    .ImWr       (ImWr),
    .ImAddr     (ImAddr),
    .ImData     (ImData),
    .Core_Run   (Core_Run),
    .Load_Error (Load_Error),
    .Word_Count (Word_Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nPass  = 0;
  int nTotal = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // ---------------- image-level model ----------------
  logic [7:0]  img[$];
  logic [31:0] expAddr[$];
  logic [31:0] expData[$];
  int          expIdx;
  int          expWords;
  bit          expErr;
  logic [31:0] firstAddr, firstData;
  int          gapTab[8] = '{2, 0, 1, 3, 0, 1, 2, 0};

  task automatic add_chk(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (img[i]) x ^= img[i];
    img.push_back(corrupt ? (x ^ 8'h5A) : x);
`else
    if (corrupt) img.push_back(8'h00);
`endif
  endtask

  task automatic model_load();
    int n;
    expAddr.delete();
    expData.delete();
    expIdx = 0;
    n = int'({img[1], img[0]});
    if (n > DEPTH) begin
      expErr   = 1'b1;
      expWords = 0;
      return;
    end
    for (int w = 0; w < n; w++) begin
      expAddr.push_back(32'(w * 4));
      expData.push_back({img[2+4*w+3], img[2+4*w+2], img[2+4*w+1], img[2+4*w]});
    end
    expWords = n;
    expErr   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) x ^= img[i];
      if (img[2+4*n] != x) expErr = 1'b1;
    end
`endif
  endtask

  // ---------------- write monitor ----------------
  always @(negedge Clk) begin
    if (Rst_n && ImWr) begin
      check("run_with_imwr", {31'd0, Core_Run}, 32'd0);
      if (expAddr.size() == 0) begin
        check("unexpected_imwr", ImAddr, 32'hFFFF_FFFF);
      end else begin
        if (expIdx == 0) begin
          firstAddr = ImAddr;
          firstData = ImData;
        end
        check("imaddr", ImAddr, expAddr[0]);
        check("imdata", ImData, expData[0]);
        check("word_count_at_wr", 32'(Word_Count), 32'(expIdx + 1));
        void'(expAddr.pop_front());
        void'(expData.pop_front());
        expIdx++;
      end
    end
  end

  // ---------------- stimulus helpers (entered at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    In_Valid = 1'b0;
    repeat (gap) @(negedge Clk);
    In_Valid = 1'b1;
    In_Data  = b;
    for (int t = 0; t < 20 && !In_Ready; t++) @(negedge Clk);
    check("in_ready_wait", {31'd0, In_Ready}, 32'd1);
    @(negedge Clk);
    In_Valid = 1'b0;
  endtask

  task automatic send_n(input int cnt, input bit gaps);
    for (int i = 0; i < cnt; i++) send_byte(img[i], gaps ? gapTab[i % 8] : 0);
  endtask

  task automatic check_end(input string tag);
    if (!expErr) begin
      check({tag, "_run_k"}, {31'd0, Core_Run}, 32'd0);
      @(negedge Clk);
      check({tag, "_run_k1"}, {31'd0, Core_Run}, 32'd0);
      @(negedge Clk);
      check({tag, "_run_k2"}, {31'd0, Core_Run}, 32'd1);
      check({tag, "_err"}, {31'd0, Load_Error}, 32'd0);
    end else begin
      check({tag, "_err_k"}, {31'd0, Load_Error}, 32'd1);
      repeat (2) @(negedge Clk);
      check({tag, "_err"}, {31'd0, Load_Error}, 32'd1);
      check({tag, "_run"}, {31'd0, Core_Run}, 32'd0);
    end
    check({tag, "_ready"}, {31'd0, In_Ready}, 32'd0);
    check({tag, "_wcount"}, 32'(Word_Count), 32'(expWords));
    check({tag, "_pending"}, 32'(expAddr.size()), 32'd0);
  endtask

  task automatic load(input string tag, input bit gaps);
    model_load();
    send_n(img.size(), gaps);
    check_end(tag);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    check("start_run", {31'd0, Core_Run}, 32'd0);
    check("start_err", {31'd0, Load_Error}, 32'd0);
    check("start_wcount", 32'(Word_Count), 32'd0);
    check("start_ready", {31'd0, In_Ready}, 32'd1);
  endtask

  task automatic set_image_a();
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    add_chk(1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, In_Ready}, 32'd1);
    check({tag, "_imwr"}, {31'd0, ImWr}, 32'd0);
    check({tag, "_imaddr"}, ImAddr, 32'd0);
    check({tag, "_imdata"}, ImData, 32'd0);
    check({tag, "_run"}, {31'd0, Core_Run}, 32'd0);
    check({tag, "_err"}, {31'd0, Load_Error}, 32'd0);
    check({tag, "_wcount"}, 32'(Word_Count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    Rst_n    = 1'b0;
    Start    = 1'b0;
    In_Valid = 1'b0;
    In_Data  = 8'h00;
    expErr   = 1'b0;
    expWords = 0;
    expIdx   = 0;
    firstAddr = 32'hDEAD_BEEF;
    firstData = 32'hDEAD_BEEF;
    repeat (2) @(negedge Clk);
    check_reset_values("rst");
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_release_ready", {31'd0, In_Ready}, 32'd1);

    // Two-word image at full rate.
    set_image_a();
    load("two_word", 1'b0);
    check("two_word_first_addr", firstAddr, 32'h0000_0000);
    check("two_word_first_data", firstData, 32'h00A0_0513);
    check("two_word_last_addr", ImAddr, 32'h0000_0004);
    check("two_word_last_data", ImData, 32'h0050_0593);
    check("two_word_count", 32'(Word_Count), 32'd2);

    // Zero-length image; extra bytes must not be consumed in DONE.
    pulse_start();
    img = '{8'h00, 8'h00};
    add_chk(1'b0);
    load("zero_len", 1'b0);
    In_Valid = 1'b1;
    In_Data  = 8'h55;
    repeat (3) @(negedge Clk);
    check("done_ready_low", {31'd0, In_Ready}, 32'd0);
    check("done_run_held", {31'd0, Core_Run}, 32'd1);
    // Start together with a valid byte: the byte is not taken.
    Start = 1'b1;
    @(negedge Clk);
    Start    = 1'b0;
    In_Valid = 1'b0;
    check("start_valid_ready", {31'd0, In_Ready}, 32'd1);
    check("start_valid_run", {31'd0, Core_Run}, 32'd0);
    img = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    add_chk(1'b0);
    load("one_word", 1'b0);
    check("one_word_data", ImData, 32'h1122_3344);
    check("one_word_addr", ImAddr, 32'h0000_0000);

    // Oversize length N=1025, then re-arm and load normally.
    pulse_start();
    img = '{8'h01, 8'h04};
    load("oversize", 1'b0);
    pulse_start();
    set_image_a();
    load("after_err", 1'b0);

    // Same image with stalls on In_Valid.
    pulse_start();
    set_image_a();
    load("gapped", 1'b1);
    check("gapped_last_data", ImData, 32'h0050_0593);

    // Reset mid-load, asynchronously, then a fresh load from address 0.
    pulse_start();
    set_image_a();
    model_load();
    send_n(5, 1'b0);
    #2;
    Rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    expAddr.delete();
    expData.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    set_image_a();
    load("post_rst", 1'b1);
    check("post_rst_first_addr", firstAddr, 32'h0000_0000);

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum: words land in memory but the core stays stopped.
    pulse_start();
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};
    add_chk(1'b1);
    load("bad_chk", 1'b0);
`endif

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire
